// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, one Booth step per clock
module booth_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state;
  logic [WIDTH:0]     acc, ms, sum;
  logic [WIDTH-1:0]   m, q;
  logic               q_m1;
  logic [CW-1:0]      count;
  assign ms = {m[WIDTH-1], m};
  // Booth add/subtract on the guard-extended accumulator before the shift
  always_comb
    sum = ({q[0], q_m1} == 2'b01) ? acc + ms :
          ({q[0], q_m1} == 2'b10) ? acc - ms : acc;
  // control FSM with datapath registers and registered busy/done/p
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      m     <= '0;
      count <= '0;
    end else
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= {sum[WIDTH], sum[WIDTH:1]};
          q     <= {sum[0], q[WIDTH-1:1]};
          q_m1  <= q[0];
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          p     <= {acc[WIDTH-1:0], q};
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
